// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and small helpers for the sync generator.
// Holds the stock 640x480@60 and 800x600@60 mode sets.
package vga_timing_pkg;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  // 640x480@60, 25.175 MHz pixel clock
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  // 800x600@60, 40 MHz pixel clock, positive syncs
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;
  localparam logic SVGA800_H_POL  = SYNC_ACTIVE_HIGH;
  localparam logic SVGA800_V_POL  = SYNC_ACTIVE_HIGH;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Level a sync line rests at when its pulse is not asserted.
  function automatic logic idle_level(input logic pol);
    return ~pol;
  endfunction

  localparam int VGA640_H_TOTAL = axis_total(VGA640_H_ACTIVE, VGA640_H_FP, VGA640_H_SYNC, VGA640_H_BP);
  localparam int VGA640_V_TOTAL = axis_total(VGA640_V_ACTIVE, VGA640_V_FP, VGA640_V_SYNC, VGA640_V_BP);
  localparam int SVGA800_H_TOTAL = axis_total(SVGA800_H_ACTIVE, SVGA800_H_FP, SVGA800_H_SYNC, SVGA800_H_BP);
  localparam int SVGA800_V_TOTAL = axis_total(SVGA800_V_ACTIVE, SVGA800_V_FP, SVGA800_V_SYNC, SVGA800_V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): a wrapping position counter
// plus combinational decode of the sync window and active region.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int W      = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         sync_window,
  output logic         in_active
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  if ((1 << W) < TOTAL) begin : g_width_check
    $error("vga_axis_counter: W too small for axis total");
  end

  assign wrap        = step && (count == LAST);
  // int compares keep the window end safe when it equals 2**W
  assign sync_window = (int'(count) >= ACTIVE + FP) && (int'(count) < ACTIVE + FP + SYNC);
  assign in_active   = int'(count) < ACTIVE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count <= '0;
    else if (clear)  count <= '0;
    else if (wrap)   count <= '0;
    else if (step)   count <= count + 1'b1;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync generator: integer pixel-clock divider, h/v axis
// counters and a registered output stage with line/frame start pulses.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = VGA640_H_ACTIVE,
  parameter int   H_FP     = VGA640_H_FP,
  parameter int   H_SYNC   = VGA640_H_SYNC,
  parameter int   H_BP     = VGA640_H_BP,
  parameter int   V_ACTIVE = VGA640_V_ACTIVE,
  parameter int   V_FP     = VGA640_V_FP,
  parameter int   V_SYNC   = VGA640_V_SYNC,
  parameter int   V_BP     = VGA640_V_BP,
  parameter logic H_POL    = SYNC_ACTIVE_LOW,
  parameter logic V_POL    = SYNC_ACTIVE_LOW,
  parameter int   CLK_DIV  = 1,
  parameter int   HW       = 10,
  parameter int   VW       = 10
) (
  input  logic          clkin,
  input  logic          rst_n,
  input  logic          en,
  output logic          pix_ce,
  output logic          hout,
  output logic          vout,
  output logic          blank,
  output logic          de,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam logic       H_IDLE   = idle_level(H_POL);
  localparam logic       V_IDLE   = idle_level(V_POL);
  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_check
    $error("vga_timing_gen: CLK_DIV must be in 1..16");
  end

  logic [3:0]    div;
  logic          step;
  logic          first_cycle;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          h_wrap, h_sync, h_act;
  logic          v_sync, v_act;
  logic          unused_v_wrap;

  assign step        = en && (div == DIV_LAST);
  // Each pixel's counter value is held across the whole divider sweep,
  // so divider zero marks the first clkin cycle of a pixel.
  assign first_cycle = (div == 4'd0);

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n)                     div <= '0;
    else if (!en || div == DIV_LAST) div <= '0;
    else                            div <= div + 4'd1;
  end

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(HW)
  ) u_h (
    .clk(clkin), .rst_n(rst_n), .step(step), .clear(!en),
    .count(h), .wrap(h_wrap), .sync_window(h_sync), .in_active(h_act)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(VW)
  ) u_v (
    .clk(clkin), .rst_n(rst_n), .step(h_wrap), .clear(!en),
    .count(v), .wrap(unused_v_wrap), .sync_window(v_sync), .in_active(v_act)
  );

  // Output stage: one clkin of latency behind the counters; en low
  // forces the same idle values as reset.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n || !en) begin
      pix_ce      <= 1'b0;
      hout        <= H_IDLE;
      vout        <= V_IDLE;
      blank       <= 1'b1;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_ce      <= step;
      hout        <= h_sync ? H_POL : H_IDLE;
      vout        <= v_sync ? V_POL : V_IDLE;
      blank       <= !(h_act && v_act);
      de          <= h_act && v_act;
      x           <= h;
      y           <= v;
      line_start  <= first_cycle && (h == '0);
      frame_start <= first_cycle && (h == '0) && (v == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default mode, a small CLK_DIV=1
// mode and a small CLK_DIV=3 positive-sync mode) under a per-cycle scoreboard.
module tb_vga_timing_gen;

  localparam int S_HA = 16, S_HF = 4, S_HS = 6, S_HB = 6;
  localparam int S_VA = 8,  S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int B_DIV = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en_a  = 1'b0;
  logic en_b  = 1'b0;
  logic en_c  = 1'b0;

  logic       pix_ce_a, hout_a, vout_a, blank_a, de_a, line_start_a, frame_start_a;
  logic [5:0] x_a;
  logic [3:0] y_a;
  logic       pix_ce_b, hout_b, vout_b, blank_b, de_b, line_start_b, frame_start_b;
  logic [5:0] x_b;
  logic [3:0] y_b;
  logic       pix_ce_c, hout_c, vout_c, blank_c, de_c, line_start_c, frame_start_c;
  logic [9:0] x_c;
  logic [9:0] y_c;

  int checks = 0;
  int errors = 0;
  int k_a = 0, k_b = 0, k_c = 0;
  logic [31:0] exp_a_q[$];
  logic [31:0] exp_b_q[$];
  logic [31:0] exp_c_q[$];
  logic [31:0] e_a, e_b, e_c;
  logic [31:0] act_a, act_b, act_c;

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .H_POL(1'b0), .V_POL(1'b0), .CLK_DIV(1), .HW(6), .VW(4)
  ) dut_a (
    .clkin(clk), .rst_n(rst_n), .en(en_a), .pix_ce(pix_ce_a), .hout(hout_a),
    .vout(vout_a), .blank(blank_a), .de(de_a), .x(x_a), .y(y_a),
    .line_start(line_start_a), .frame_start(frame_start_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(B_DIV), .HW(6), .VW(4)
  ) dut_b (
    .clkin(clk), .rst_n(rst_n), .en(en_b), .pix_ce(pix_ce_b), .hout(hout_b),
    .vout(vout_b), .blank(blank_b), .de(de_b), .x(x_b), .y(y_b),
    .line_start(line_start_b), .frame_start(frame_start_b)
  );

  vga_timing_gen dut_c (
    .clkin(clk), .rst_n(rst_n), .en(en_c), .pix_ce(pix_ce_c), .hout(hout_c),
    .vout(vout_c), .blank(blank_c), .de(de_c), .x(x_c), .y(y_c),
    .line_start(line_start_c), .frame_start(frame_start_c)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // k counts output cycles since enable; pixel index = k / div.
  function automatic logic [31:0] model_out(input bit run, input int k,
      input int ha, input int hf, input int hs, input int hb,
      input int va, input int vf, input int vs, input int vb,
      input int div, input bit hpol, input bit vpol);
    int ht, vt, p, h, v;
    bit hsync, vsync, act, first;
    logic [31:0] r;
    r = '0;
    if (!run) begin
      r[21] = ~hpol;
      r[22] = ~vpol;
      r[23] = 1'b1;
      return r;
    end
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    p = k / div;
    h = p % ht;
    v = (p / ht) % vt;
    hsync = (h >= ha + hf) && (h < ha + hf + hs);
    vsync = (v >= va + vf) && (v < va + vf + vs);
    act = (h < ha) && (v < va);
    first = (k % div) == 0;
    r[9:0]   = 10'(h);
    r[19:10] = 10'(v);
    r[20] = (k % div) == (div - 1);
    r[21] = hsync ? hpol : ~hpol;
    r[22] = vsync ? vpol : ~vpol;
    r[23] = ~act;
    r[24] = act;
    r[25] = first && (h == 0);
    r[26] = first && (h == 0) && (v == 0);
    return r;
  endfunction

  function automatic logic [31:0] exp_a(input bit run, input int k);
    return model_out(run, k, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1, 1'b0, 1'b0);
  endfunction
  function automatic logic [31:0] exp_b(input bit run, input int k);
    return model_out(run, k, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, B_DIV, 1'b1, 1'b1);
  endfunction
  function automatic logic [31:0] exp_c(input bit run, input int k);
    return model_out(run, k, 640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b0, 1'b0);
  endfunction

  function automatic logic [31:0] pack_out(input logic pc, input logic hs, input logic vs,
      input logic bl, input logic d, input logic ls, input logic fs,
      input logic [9:0] xx, input logic [9:0] yy);
    return {5'd0, fs, ls, d, bl, vs, hs, pc, yy, xx};
  endfunction

  assign act_a = pack_out(pix_ce_a, hout_a, vout_a, blank_a, de_a, line_start_a, frame_start_a, 10'(x_a), 10'(y_a));
  assign act_b = pack_out(pix_ce_b, hout_b, vout_b, blank_b, de_b, line_start_b, frame_start_b, 10'(x_b), 10'(y_b));
  assign act_c = pack_out(pix_ce_c, hout_c, vout_c, blank_c, de_c, line_start_c, frame_start_c, x_c, y_c);

  // ---------------- scoreboard: push on the active edge ----------------
  always @(posedge clk) begin
    if (rst_n && en_a) begin exp_a_q.push_back(exp_a(1'b1, k_a)); k_a++; end
    else begin exp_a_q.push_back(exp_a(1'b0, 0)); k_a = 0; end
    if (rst_n && en_b) begin exp_b_q.push_back(exp_b(1'b1, k_b)); k_b++; end
    else begin exp_b_q.push_back(exp_b(1'b0, 0)); k_b = 0; end
    if (rst_n && en_c) begin exp_c_q.push_back(exp_c(1'b1, k_c)); k_c++; end
    else begin exp_c_q.push_back(exp_c(1'b0, 0)); k_c = 0; end
  end

  // ---------------- scoreboard: pop and compare on the opposite edge ----------------
  always @(negedge clk) begin
    checks++;
    if (exp_a_q.size() == 0) begin errors++; $display("FAIL sb_a: expected queue empty at %0t", $time); end
    else begin
      e_a = exp_a_q.pop_front();
      if (act_a !== e_a) begin errors++; $display("FAIL sb_a @%0t: got %h want %h", $time, act_a, e_a); end
    end
    checks++;
    if (exp_b_q.size() == 0) begin errors++; $display("FAIL sb_b: expected queue empty at %0t", $time); end
    else begin
      e_b = exp_b_q.pop_front();
      if (act_b !== e_b) begin errors++; $display("FAIL sb_b @%0t: got %h want %h", $time, act_b, e_b); end
    end
    checks++;
    if (exp_c_q.size() == 0) begin errors++; $display("FAIL sb_c: expected queue empty at %0t", $time); end
    else begin
      e_c = exp_c_q.pop_front();
      if (act_c !== e_c) begin errors++; $display("FAIL sb_c @%0t: got %h want %h", $time, act_c, e_c); end
    end
  end

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (act_a !== exp_a(1'b0, 0)) begin errors++; $display("FAIL reset_a: got %h want %h", act_a, exp_a(1'b0, 0)); end
    checks++;
    if (act_c !== exp_c(1'b0, 0)) begin errors++; $display("FAIL reset_c: got %h want %h", act_c, exp_c(1'b0, 0)); end
    checks++;
    if (hout_b !== 1'b0) begin errors++; $display("FAIL reset_hout_pos: got %b want 0", hout_b); end
    checks++;
    if (vout_b !== 1'b0) begin errors++; $display("FAIL reset_vout_pos: got %b want 0", vout_b); end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_horizontal();
    int ls_t[$];
    int hfall, hrise, brise, ls0, period;
    logic ph, pb;
    hfall = -1; hrise = -1; brise = -1; ph = 1'b1; pb = 1'b1;
    @(negedge clk);
    #1 en_c = 1'b1;
    for (int i = 0; i < 1700; i++) begin
      @(negedge clk);
      if (line_start_c === 1'b1) ls_t.push_back(i);
      if (ph === 1'b1 && hout_c === 1'b0 && hfall < 0) hfall = i;
      if (ph === 1'b0 && hout_c === 1'b1 && hfall >= 0 && hrise < 0) hrise = i;
      if (pb === 1'b0 && blank_c === 1'b1 && brise < 0) brise = i;
      ph = hout_c;
      pb = blank_c;
    end
    ls0 = (ls_t.size() > 0) ? ls_t[0] : -10000;
    period = (ls_t.size() > 1) ? ls_t[1] - ls_t[0] : -1;
    checks++;
    if (ls_t.size() != 3) begin errors++; $display("FAIL h_line_count: got %0d want 3", ls_t.size()); end
    checks++;
    if (period != 800) begin errors++; $display("FAIL h_line_period: got %0d want 800", period); end
    checks++;
    if (hfall - ls0 != 656) begin errors++; $display("FAIL h_sync_start: got %0d want 656", hfall - ls0); end
    checks++;
    if (hrise - hfall != 96) begin errors++; $display("FAIL h_sync_width: got %0d want 96", hrise - hfall); end
    checks++;
    if (brise - ls0 != 640) begin errors++; $display("FAIL h_blank_start: got %0d want 640", brise - ls0); end
  endtask

  task automatic test_vertical();
    int fs_t[$];
    int vfall, vrise, de_bad, period, fs0;
    logic [3:0] y_fall;
    logic [5:0] x_fall;
    logic pv;
    vfall = -1; vrise = -1; de_bad = 0; pv = 1'b1; y_fall = '0; x_fall = '1;
    @(negedge clk);
    #1 en_a = 1'b1;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (frame_start_a === 1'b1) fs_t.push_back(i);
      if (pv === 1'b1 && vout_a === 1'b0 && vfall < 0) begin vfall = i; y_fall = y_a; x_fall = x_a; end
      if (pv === 1'b0 && vout_a === 1'b1 && vfall >= 0 && vrise < 0) vrise = i;
      if (de_a === 1'b1 && y_a >= 4'd8) de_bad++;
      pv = vout_a;
    end
    fs0 = (fs_t.size() > 0) ? fs_t[0] : -10000;
    period = (fs_t.size() > 1) ? fs_t[1] - fs_t[0] : -1;
    checks++;
    if (fs_t.size() != 3) begin errors++; $display("FAIL v_frame_count: got %0d want 3", fs_t.size()); end
    checks++;
    if (period != 480) begin errors++; $display("FAIL v_frame_period: got %0d want 480", period); end
    checks++;
    if (vfall - fs0 != 320) begin errors++; $display("FAIL v_sync_start: got %0d want 320", vfall - fs0); end
    checks++;
    if (vrise - vfall != 64) begin errors++; $display("FAIL v_sync_width: got %0d want 64", vrise - vfall); end
    checks++;
    if (y_fall !== 4'd10 || x_fall !== 6'd0) begin errors++; $display("FAIL v_sync_pos: got y=%0d x=%0d want y=10 x=0", y_fall, x_fall); end
    checks++;
    if (de_bad != 0) begin errors++; $display("FAIL v_de_in_blank: got %0d cycles want 0", de_bad); end
  endtask

  task automatic test_clk_div();
    int ls_t[$];
    int pc_cnt, pc_pairs, x_chg, hrise, hfall, period;
    logic ppc, ph;
    logic [5:0] px;
    logic h_first, v_first;
    pc_cnt = 0; pc_pairs = 0; x_chg = 0; hrise = -1; hfall = -1;
    ppc = 1'b0; ph = 1'b0; px = '0; h_first = 1'b1; v_first = 1'b1;
    @(negedge clk);
    #1 en_b = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 0) begin h_first = hout_b; v_first = vout_b; end
      if (pix_ce_b === 1'b1) pc_cnt++;
      if (pix_ce_b === 1'b1 && ppc === 1'b1) pc_pairs++;
      if (x_b !== px) x_chg++;
      if (line_start_b === 1'b1) ls_t.push_back(i);
      if (ph === 1'b0 && hout_b === 1'b1 && hrise < 0) hrise = i;
      if (ph === 1'b1 && hout_b === 1'b0 && hrise >= 0 && hfall < 0) hfall = i;
      ppc = pix_ce_b; ph = hout_b; px = x_b;
    end
    period = (ls_t.size() > 1) ? ls_t[1] - ls_t[0] : -1;
    checks++;
    if (pc_cnt != 100) begin errors++; $display("FAIL div_pix_ce_count: got %0d want 100", pc_cnt); end
    checks++;
    if (pc_pairs != 0) begin errors++; $display("FAIL div_pix_ce_adjacent: got %0d want 0", pc_pairs); end
    checks++;
    if (x_chg != 99) begin errors++; $display("FAIL div_x_steps: got %0d want 99", x_chg); end
    checks++;
    if (period != 96) begin errors++; $display("FAIL div_line_period: got %0d want 96", period); end
    checks++;
    if (hrise != 60 || hfall - hrise != 18) begin errors++; $display("FAIL div_hsync: got start %0d len %0d want 60 18", hrise, hfall - hrise); end
    checks++;
    if (h_first !== 1'b0 || v_first !== 1'b0) begin errors++; $display("FAIL pol_idle: got h=%b v=%b want 0 0", h_first, v_first); end
  endtask

  task automatic test_en_drop();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 9000 && !found; i++) begin
      @(negedge clk);
      if (x_c === 10'd300 && y_c === 10'd5) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL en_drop_wait: got no x=300 y=5 want reached"); end
    #1 en_c = 1'b0;
    @(negedge clk);
    checks++;
    if (x_c !== 10'd0 || y_c !== 10'd0) begin errors++; $display("FAIL en_drop_xy: got %0d,%0d want 0,0", x_c, y_c); end
    checks++;
    if (blank_c !== 1'b1 || de_c !== 1'b0) begin errors++; $display("FAIL en_drop_blank: got blank=%b de=%b want 1 0", blank_c, de_c); end
    checks++;
    if (hout_c !== 1'b1 || vout_c !== 1'b1) begin errors++; $display("FAIL en_drop_sync: got %b%b want 11", hout_c, vout_c); end
    checks++;
    if ({pix_ce_c, line_start_c, frame_start_c} !== 3'b000) begin errors++; $display("FAIL en_drop_pulses: got %b want 000", {pix_ce_c, line_start_c, frame_start_c}); end
    repeat (2) @(negedge clk);
    #1 en_c = 1'b1;
    @(negedge clk);
    checks++;
    if (frame_start_c !== 1'b1 || line_start_c !== 1'b1) begin errors++; $display("FAIL en_rise_pulses: got fs=%b ls=%b want 1 1", frame_start_c, line_start_c); end
    checks++;
    if (x_c !== 10'd0 || y_c !== 10'd0) begin errors++; $display("FAIL en_rise_xy: got %0d,%0d want 0,0", x_c, y_c); end
  endtask

  task automatic test_async_reset();
    repeat (37) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (act_a !== exp_a(1'b0, 0)) begin errors++; $display("FAIL areset_a: got %h want %h", act_a, exp_a(1'b0, 0)); end
    checks++;
    if (act_b !== exp_b(1'b0, 0)) begin errors++; $display("FAIL areset_b: got %h want %h", act_b, exp_b(1'b0, 0)); end
    checks++;
    if (act_c !== exp_c(1'b0, 0)) begin errors++; $display("FAIL areset_c: got %h want %h", act_c, exp_c(1'b0, 0)); end
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (frame_start_c !== 1'b1 || line_start_c !== 1'b1 || x_c !== 10'd0) begin
      errors++; $display("FAIL areset_restart_c: got fs=%b ls=%b x=%0d want 1 1 0", frame_start_c, line_start_c, x_c);
    end
    checks++;
    if (frame_start_a !== 1'b1 || frame_start_b !== 1'b1) begin
      errors++; $display("FAIL areset_restart_ab: got fs_a=%b fs_b=%b want 1 1", frame_start_a, frame_start_b);
    end
    repeat (200) @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_horizontal();
    test_vertical();
    test_clk_div();
    test_en_drop();
    test_async_reset();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA sync generator. Successor to the fixed 640x480 hout/vout generator.
- Runs from the board clock `clkin` and produces `pix_ce`, a pixel-clock enable set by an integer divider.
- Adds run-time gating (`en`), configurable sync polarity, blanking/data-enable, pixel coordinates, and line/frame start pulses.
- Sits between the clock input and the pixel/framebuffer logic; the top level feeds hout/vout to the connector.

Parameters:
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- H_POL, 0: hsync active level (0 = active-low).
- V_POL, 0: vsync active level (0 = active-low).
- CLK_DIV, 1: clkin cycles per pixel; valid range 1..16.
- HW, 10: width of x; elaboration fails unless 2^HW >= H_TOTAL.
- VW, 10: width of y; elaboration fails unless 2^VW >= V_TOTAL.

Ports:
- clkin  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run enable; low freezes the generator at (0,0), idle.
- pix_ce  out  1  one-clkin-cycle pulse, once per pixel.
- hout  out  1  horizontal sync, polarity set by H_POL.
- vout  out  1  vertical sync, polarity set by V_POL.
- blank  out  1  high outside the active region.
- de  out  1  equal to ~blank.
- x  out  HW  current pixel column.
- y  out  VW  current line.
- line_start  out  1  one-cycle pulse on the first output cycle of each line.
- frame_start  out  1  one-cycle pulse on the first output cycle of each frame.

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL likewise (default 525).
- Reset (rst_n low) takes effect asynchronously, with no clock edge needed, including mid-frame:
  - divider and h/v counters go to 0;
  - pix_ce=0, line_start=0, frame_start=0, x=0, y=0;
  - blank=1, de=0;
  - hout=~H_POL and vout=~V_POL (sync deasserted).
- Divider: counts 0..CLK_DIV-1 while en=1. pix_ce is high in the cycle the divider equals CLK_DIV-1. For CLK_DIV=1, pix_ce is constantly high while enabled.
- h counter: advances on pix_ce and wraps H_TOTAL-1 -> 0.
- v counter: advances when h wraps, and itself wraps V_TOTAL-1 -> 0.
- Outputs are registered from the counter state, with exactly 1 clkin cycle of latency. Each output value is held for CLK_DIV clkin cycles.
- Decoding:
  - hout is active when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vout uses the same window rule applied to v.
  - blank = (h >= H_ACTIVE) | (v >= V_ACTIVE).
- x and y always show the counters, including during blanking.
- line_start: high for exactly one clkin cycle, on the first cycle that the outputs show h=0.
- frame_start: same rule, for h=0 and v=0; it coincides with that line's line_start.
- en low (sampled synchronously):
  - next cycle, divider and counters are 0;
  - all outputs return to their reset values;
  - no pulses are generated.
- en rising: the first output cycle shows (0,0) and raises line_start and frame_start. Counting then proceeds normally.
- Simultaneous h-wrap and v-wrap in the same pix_ce: both wrap; frame_start fires.
- Parameter changes require re-elaboration; there is no run-time mode register.

Decomposition:
- Package vga_timing_pkg holds:
  - the default 640x480@60 constants;
  - an 800x600@60 constant set (40 MHz);
  - the derived-total and polarity-idle helper constants.
- Sub-module vga_axis_counter, instantiated twice (horizontal and vertical):
  - parameters ACTIVE/FP/SYNC/BP/W;
  - inputs: step, clear;
  - outputs: count, wrap, sync_window, in_active.
- The top level holds the divider, enable gating, output registers and pulse logic.

Test Plan:
- Defaults, CLK_DIV=1, en=1 after reset:
  - line_start every 800 cycles;
  - hout low for exactly 96 cycles, starting 656 cycles after the line_start rise;
  - blank rises 640 cycles after line_start.
- Defaults, vertical timing:
  - frame_start every 420000 cycles;
  - vout low for exactly 1600 cycles, starting at y=490;
  - de never high while y >= 480.
- CLK_DIV=4:
  - pix_ce is high 1 cycle in 4;
  - line period is 3200 cycles and hout low lasts 384 cycles;
  - x steps once per 4 clkin cycles.
- H_POL=1, V_POL=1:
  - hout and vout idle low and pulse high in the same windows;
  - reset values of hout and vout are 0.
- Drop en when x=300, y=5:
  - next cycle: x=0, y=0, blank=1, sync idle, no pulses;
  - re-raise en: the first output cycle has frame_start=1 and line_start=1.
- Assert rst_n low mid-line, between clock edges:
  - outputs reach reset values immediately;
  - after release with en=1, timing restarts from (0,0) with a frame_start pulse.
